botones_debounce_puertas: RTL and testbench

//  N-channel button front end: 2-flop sync, counter debounce, rise/fall pulses per channel.

---
 rtl/botones_debounce_puertas_pkg.sv | 16 +
 rtl/boton_debounce_canal.sv | 49 ++++
 rtl/botones_debounce_puertas.sv | 72 +++++++
 tb/tb_botones_debounce_puertas.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/botones_debounce_puertas_pkg.sv
// Shared gate-select codes for the button front end and the game logic.
// Optional feature macro for the top level: BOTONES_TOGGLE_EN.
package botones_debounce_puertas_pkg;

  localparam int PUERTA_W = 3;

  localparam logic [PUERTA_W-1:0] PUERTA_OR   = 3'd0;
  localparam logic [PUERTA_W-1:0] PUERTA_AND  = 3'd1;
  localparam logic [PUERTA_W-1:0] PUERTA_XOR  = 3'd2;
  localparam logic [PUERTA_W-1:0] PUERTA_NOT  = 3'd3;
  localparam logic [PUERTA_W-1:0] PUERTA_NAND = 3'd4;
  localparam logic [PUERTA_W-1:0] PUERTA_NOR  = 3'd5;
  localparam logic [PUERTA_W-1:0] PUERTA_XNOR = 3'd6;
  localparam logic [PUERTA_W-1:0] PUERTA_CERO = 3'd7;

endpackage

// File: rtl/boton_debounce_canal.sv
// One button channel: two-flop synchroniser, saturating stability counter,
// debounced level and registered rise/fall pulses.
module boton_debounce_canal #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  output logic estable,
  output logic flanco_sub,
  output logic flanco_baj
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  // Stage p0/p1: metastability filter; only sync_p1 reaches the counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      cnt        <= '0;
      estable    <= 1'b0;
      flanco_sub <= 1'b0;
      flanco_baj <= 1'b0;
    end else begin
      sync_p0    <= boton;
      sync_p1    <= sync_p0;
      flanco_sub <= 1'b0;
      flanco_baj <= 1'b0;
      if (sync_p1 == estable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Accepting clears the counter, so it can never wrap.
        estable    <= sync_p1;
        cnt        <= '0;
        flanco_sub <= sync_p1;
        flanco_baj <= ~sync_p1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/botones_debounce_puertas.sv
// N-channel debounced button front end with a runtime-selected reduction gate.
// Define BOTONES_TOGGLE_EN to build the per-channel press-toggle register.
module botones_debounce_puertas
  import botones_debounce_puertas_pkg::*;
#(
  parameter int N_BOTONES       = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BOTONES-1:0] botones,
  input  logic [2:0]           sel_puerta,
  output logic [N_BOTONES-1:0] estable,
  output logic [N_BOTONES-1:0] flanco_sub,
  output logic [N_BOTONES-1:0] flanco_baj,
  output logic                 puerta_out,
  output logic [N_BOTONES-1:0] conmutado
);

  function automatic logic puerta(input logic [N_BOTONES-1:0] v,
                                  input logic [PUERTA_W-1:0]  sel);
    logic r;
    r = 1'b0;
    case (sel)
      PUERTA_OR:   r = |v;
      PUERTA_AND:  r = &v;
      PUERTA_XOR:  r = ^v;
      PUERTA_NOT:  r = ~v[0];
      PUERTA_NAND: r = ~(&v);
      PUERTA_NOR:  r = ~(|v);
      PUERTA_XNOR: r = ~(^v);
      PUERTA_CERO: r = 1'b0;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

  for (genvar i = 0; i < N_BOTONES; i++) begin : g_canal
    boton_debounce_canal #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_canal (
      .clk       (clk),
      .reset     (reset),
      .boton     (botones[i]),
      .estable   (estable[i]),
      .flanco_sub(flanco_sub[i]),
      .flanco_baj(flanco_baj[i])
    );
  end

  // Stage p2: gate result registered one cycle behind estable/sel_puerta.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      puerta_out <= 1'b0;
    end else begin
      puerta_out <= puerta(estable, sel_puerta);
    end
  end

`ifdef BOTONES_TOGGLE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conmutado <= '0;
    end else begin
      conmutado <= conmutado ^ flanco_sub;
    end
  end
`else
  assign conmutado = '0;
`endif

endmodule

// File: tb/tb_botones_debounce_puertas.sv
// Directed bench for botones_debounce_puertas (N_BOTONES=2, DEBOUNCE_CYCLES=4);
// expectations are queued by cycle and checked by an independent monitor.
module tb_botones_debounce_puertas;

  localparam int N = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] botones;
  logic [2:0]   sel_puerta;
  logic [N-1:0] estable, flanco_sub, flanco_baj, conmutado;
  logic         puerta_out;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int           at;
    logic [N-1:0] est;
    logic [N-1:0] fs;
    logic [N-1:0] fb;
    bit           chk_pu;
    logic         pu;
    bit           chk_cm;
    logic [N-1:0] cm;
    string        name;
  } exp_t;

  exp_t q[$];

  botones_debounce_puertas #(
    .N_BOTONES      (N),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .botones   (botones),
    .sel_puerta(sel_puerta),
    .estable   (estable),
    .flanco_sub(flanco_sub),
    .flanco_baj(flanco_baj),
    .puerta_out(puerta_out),
    .conmutado (conmutado)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int dc, input logic [N-1:0] est, input logic [N-1:0] fs,
                           input logic [N-1:0] fb, input bit chk_pu, input logic pu,
                           input bit chk_cm, input logic [N-1:0] cm, input string name);
    exp_t e;
    e.at = cyc + dc; e.est = est; e.fs = fs; e.fb = fb;
    e.chk_pu = chk_pu; e.pu = pu; e.chk_cm = chk_cm; e.cm = cm; e.name = name;
    q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Monitor: outputs are presented every cycle; pop whatever is due now.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      total++;
      if (e.at != cyc) begin
        bad++;
        $display("FAIL %s: check slot missed at cycle %0d, required cycle %0d", e.name, cyc, e.at);
      end else if (estable !== e.est || flanco_sub !== e.fs || flanco_baj !== e.fb ||
                   (e.chk_pu && puerta_out !== e.pu) || (e.chk_cm && conmutado !== e.cm)) begin
        bad++;
        $display("FAIL %s @%0d: got est=%b sub=%b baj=%b pu=%b cm=%b, want est=%b sub=%b baj=%b pu=%b(chk %0d) cm=%b(chk %0d)",
                 e.name, cyc, estable, flanco_sub, flanco_baj, puerta_out, conmutado,
                 e.est, e.fs, e.fb, e.pu, e.chk_pu, e.cm, e.chk_cm);
      end
    end
  end

  initial begin
    logic [7:0]   sweep;
    logic [N-1:0] cm_exp;
    sweep = 8'b0001_1101;  // bit k = expected gate k over estable=2'b10
    reset = 1'b0;
    botones = 2'b11;
    sel_puerta = 3'd4;

    // Reset held with buttons pressed and NAND selected: everything reads 0.
    step(3);
    expect_at(0, 2'b00, 2'b00, 2'b00, 1, 1'b0, 1, 2'b00, "reset_state");
    step(1);

    // Release: NAND of all-zero estable appears one edge later; estable at edge 6.
    reset = 1'b1;
    for (int k = 1; k <= 5; k++)
      expect_at(k, 2'b00, 2'b00, 2'b00, 1, 1'b1, 0, 2'b00, "release_hold");
    expect_at(6, 2'b11, 2'b11, 2'b00, 1, 1'b1, 0, 2'b00, "release_accept");
    expect_at(7, 2'b11, 2'b00, 2'b00, 1, 1'b0, 0, 2'b00, "release_pulse_end");
    step(8);

    // Channel 0 release then press, channel 1 untouched.
    sel_puerta = 3'd0;
    botones = 2'b10;
    expect_at(5, 2'b11, 2'b00, 2'b00, 0, 1'b0, 0, 2'b00, "fall0_hold");
    expect_at(6, 2'b10, 2'b00, 2'b01, 0, 1'b0, 0, 2'b00, "fall0_accept");
    expect_at(7, 2'b10, 2'b00, 2'b00, 0, 1'b0, 0, 2'b00, "fall0_pulse_end");
    step(8);
    botones = 2'b11;
    expect_at(5, 2'b10, 2'b00, 2'b00, 0, 1'b0, 0, 2'b00, "rise0_hold");
    expect_at(6, 2'b11, 2'b01, 2'b00, 0, 1'b0, 0, 2'b00, "rise0_accept");
    expect_at(7, 2'b11, 2'b00, 2'b00, 0, 1'b0, 0, 2'b00, "rise0_pulse_end");
    step(8);

    // Bring channel 1 low, then a 3-cycle glitch on it must be rejected.
    botones = 2'b01;
    expect_at(6, 2'b01, 2'b00, 2'b10, 0, 1'b0, 0, 2'b00, "fall1_accept");
    step(8);
    botones = 2'b11;
    for (int k = 1; k <= 10; k++)
      expect_at(k, 2'b01, 2'b00, 2'b00, 0, 1'b0, 0, 2'b00, "glitch1");
    step(3);
    botones = 2'b01;
    step(9);

    // Both channels flip together to estable=2'b10.
    botones = 2'b10;
    expect_at(5, 2'b01, 2'b00, 2'b00, 0, 1'b0, 0, 2'b00, "both_hold");
    expect_at(6, 2'b10, 2'b10, 2'b01, 0, 1'b0, 0, 2'b00, "both_accept");
    step(8);

    // Gate sweep over estable=2'b10.
    for (int k = 0; k < 8; k++) begin
      sel_puerta = 3'(k);
      expect_at(1, 2'b10, 2'b00, 2'b00, 1, sweep[k], 0, 2'b00, $sformatf("gate_sel%0d", k));
      step(1);
    end
    step(2);

    // Reset mid-debounce (cnt=2 on channel 0), then full latency again.
    sel_puerta = 3'd4;
    botones = 2'b11;
    step(4);
    reset = 1'b0;
    expect_at(0, 2'b00, 2'b00, 2'b00, 1, 1'b0, 1, 2'b00, "midreset_clear");
    step(2);
    reset = 1'b1;
    expect_at(5, 2'b00, 2'b00, 2'b00, 0, 1'b0, 0, 2'b00, "midreset_hold");
    expect_at(6, 2'b11, 2'b11, 2'b00, 0, 1'b0, 0, 2'b00, "midreset_accept");
    step(8);

    // Three presses on channel 0: toggle register (if built) goes 1,0,1.
    reset = 1'b0;
    botones = 2'b00;
    step(2);
    reset = 1'b1;
    step(3);
    cm_exp = 2'b00;
    for (int p = 0; p < 3; p++) begin
      botones = 2'b01;
      expect_at(6, 2'b01, 2'b01, 2'b00, 0, 1'b0, 1, cm_exp, $sformatf("press%0d_before", p));
`ifdef BOTONES_TOGGLE_EN
      cm_exp = cm_exp ^ 2'b01;
`endif
      expect_at(8, 2'b01, 2'b00, 2'b00, 0, 1'b0, 1, cm_exp, $sformatf("press%0d_after", p));
      step(8);
      botones = 2'b00;
      expect_at(6, 2'b00, 2'b00, 2'b01, 0, 1'b0, 1, cm_exp, $sformatf("press%0d_release", p));
      step(8);
    end

    step(3);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d checks left unserviced, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
